// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-port synchronous data memory.
// Grants one access per cycle, drives dmem from the winner, and routes the
// registered response (read data / error) back to the port that owns it.
module dmem_arbiter #(
  parameter int unsigned MEM_ADDR_WIDTH = 12,
  parameter int unsigned ARB_MODE       = 0,
  parameter int unsigned STARVE_LIMIT   = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_req,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wr_data,
  input  logic [3:0]  i_m0_size,
  input  logic        i_m0_write,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  output logic [31:0] o_m0_rd_data,
  output logic        o_m0_err,
  input  logic        i_m1_req,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wr_data,
  input  logic [3:0]  i_m1_size,
  input  logic        i_m1_write,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m1_rd_data,
  output logic        o_m1_err,
  output logic [31:0] o_data_addr,
  output logic [31:0] o_data_wr_data,
  output logic [3:0]  o_data_size,
  output logic        o_data_write,
  output logic        o_data_read,
  input  logic [31:0] i_data_rd_data
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SIZE_W  = 4;

  // rr_last: 0 = port 0 granted last, 1 = port 1 granted last
  logic             rr_last_q, rr_last_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_owner_q, resp_owner_d;
  logic             resp_err_q, resp_err_d;
  logic             resp_is_read_q, resp_is_read_d;

  logic              gnt0, gnt1, any_gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wr_data;
  logic [SIZE_W-1:0] sel_size;
  logic              sel_write;
  logic              in_range;

  // Grant selection: single requester wins outright, contention resolved by mode
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!i_rst) begin
      if (i_m0_req && i_m1_req) begin
        if (ARB_MODE == 0) begin
          if (rr_last_q) gnt0 = 1'b1;
          else           gnt1 = 1'b1;
        end else begin
          if (starve_cnt_q == CNT_W'(STARVE_LIMIT)) gnt1 = 1'b1;
          else                                      gnt0 = 1'b1;
        end
      end else begin
        gnt0 = i_m0_req;
        gnt1 = i_m1_req;
      end
    end
  end

  assign any_gnt  = gnt0 | gnt1;
  assign o_m0_gnt = gnt0;
  assign o_m1_gnt = gnt1;

  // Request mux from the granted port; zeros when idle
  always_comb begin
    sel_addr    = '0;
    sel_wr_data = '0;
    sel_size    = '0;
    sel_write   = 1'b0;
    if (gnt1) begin
      sel_addr    = i_m1_addr;
      sel_wr_data = i_m1_wr_data;
      sel_size    = i_m1_size;
      sel_write   = i_m1_write;
    end else if (gnt0) begin
      sel_addr    = i_m0_addr;
      sel_wr_data = i_m0_wr_data;
      sel_size    = i_m0_size;
      sel_write   = i_m0_write;
    end
  end

  // Shift form keeps MEM_ADDR_WIDTH == 32 legal
  assign in_range       = ((sel_addr >> MEM_ADDR_WIDTH) == ADDR_W'(0));
  assign o_data_addr    = sel_addr;
  assign o_data_wr_data = sel_wr_data;
  assign o_data_size    = sel_size;
  assign o_data_write   = any_gnt & sel_write & in_range;
  assign o_data_read    = any_gnt & ~sel_write & in_range;

  // Next-state: round-robin pointer, starvation counter, response capture
  always_comb begin
    rr_last_d      = rr_last_q;
    starve_cnt_d   = starve_cnt_q;
    resp_valid_d   = any_gnt;
    resp_owner_d   = resp_owner_q;
    resp_err_d     = resp_err_q;
    resp_is_read_d = resp_is_read_q;

    if (gnt0) rr_last_d = 1'b0;
    if (gnt1) rr_last_d = 1'b1;

    if (i_m1_req && !gnt1) begin
      if (starve_cnt_q != {CNT_W{1'b1}}) starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end else begin
      starve_cnt_d = '0;
    end

    if (any_gnt) begin
      resp_owner_d   = gnt1;
      resp_err_d     = ~in_range;
      resp_is_read_d = ~sel_write;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_last_q      <= 1'b1;
      starve_cnt_q   <= '0;
      resp_valid_q   <= 1'b0;
      resp_owner_q   <= 1'b0;
      resp_err_q     <= 1'b0;
      resp_is_read_q <= 1'b0;
    end else begin
      rr_last_q      <= rr_last_d;
      starve_cnt_q   <= starve_cnt_d;
      resp_valid_q   <= resp_valid_d;
      resp_owner_q   <= resp_owner_d;
      resp_err_q     <= resp_err_d;
      resp_is_read_q <= resp_is_read_d;
    end
  end

  // Response routing to the owning port only
  assign o_m0_rvalid  = resp_valid_q & ~resp_owner_q;
  assign o_m1_rvalid  = resp_valid_q & resp_owner_q;
  assign o_m0_err     = o_m0_rvalid & resp_err_q;
  assign o_m1_err     = o_m1_rvalid & resp_err_q;
  assign o_m0_rd_data = (o_m0_rvalid && resp_is_read_q && !resp_err_q) ? i_data_rd_data : '0;
  assign o_m1_rd_data = (o_m1_rvalid && resp_is_read_q && !resp_err_q) ? i_data_rd_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: two arbiter instances (round-robin, and priority with
// STARVE_LIMIT=3) share one stimulus stream; each has its own dmem behind it.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst, preload;
  logic        r0, w0, r1, w1;
  logic [31:0] a0, d0, a1, d1;
  logic [3:0]  s0, s1;

  logic        gnt0_o [2];
  logic        gnt1_o [2];
  logic        rv0_o  [2];
  logic        rv1_o  [2];
  logic        err0_o [2];
  logic        err1_o [2];
  logic [31:0] rd0_o  [2];
  logic [31:0] rd1_o  [2];
  logic [31:0] daddr_o[2];
  logic [31:0] dwdat_o[2];
  logic [3:0]  dsize_o[2];
  logic        dwr_o  [2];
  logic        drd_o  [2];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic        m0_gnt, m1_gnt, m0_rv, m1_rv, m0_err, m1_err;
    logic [31:0] m0_rd, m1_rd, daddr, dwdat, rdq;
    logic [3:0]  dsize;
    logic        dwr, drd;
    logic [31:0] mem [1024];

    dmem_arbiter #(.MEM_ADDR_WIDTH(12), .ARB_MODE(k), .STARVE_LIMIT(3)) u_dut (
      .i_clk(clk), .i_rst(rst),
      .i_m0_req(r0), .i_m0_addr(a0), .i_m0_wr_data(d0), .i_m0_size(s0), .i_m0_write(w0),
      .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rv), .o_m0_rd_data(m0_rd), .o_m0_err(m0_err),
      .i_m1_req(r1), .i_m1_addr(a1), .i_m1_wr_data(d1), .i_m1_size(s1), .i_m1_write(w1),
      .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rv), .o_m1_rd_data(m1_rd), .o_m1_err(m1_err),
      .o_data_addr(daddr), .o_data_wr_data(dwdat), .o_data_size(dsize),
      .o_data_write(dwr), .o_data_read(drd), .i_data_rd_data(rdq)
    );

    // Single-port synchronous memory, 1-cycle read latency, byte-lane writes
    always @(posedge clk) begin
      if (preload) begin
        for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      end else begin
        if (dwr)
          for (int b = 0; b < 4; b++)
            if (dsize[b]) mem[daddr[11:2]][8*b +: 8] <= dwdat[8*b +: 8];
        if (drd) rdq <= mem[daddr[11:2]];
      end
    end

    assign gnt0_o[k] = m0_gnt;  assign gnt1_o[k] = m1_gnt;
    assign rv0_o[k]  = m0_rv;   assign rv1_o[k]  = m1_rv;
    assign err0_o[k] = m0_err;  assign err1_o[k] = m1_err;
    assign rd0_o[k]  = m0_rd;   assign rd1_o[k]  = m1_rd;
    assign daddr_o[k] = daddr;  assign dwdat_o[k] = dwdat;
    assign dsize_o[k] = dsize;  assign dwr_o[k]   = dwr;
    assign drd_o[k]   = drd;
  end

  // Reference model state (index 0: round-robin, 1: priority, limit 3)
  int          m_last  [2];
  int          m_starve[2];
  bit          pv[2], pr[2], pe[2];
  int          po[2];
  logic [31:0] pd[2];
  logic [31:0] rmem[2][1024];
  int          obs_g[2];
  logic [31:0] obs_rd0[2];
  logic        obs_rv1[2], obs_err1[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant(input int k);
    if (rst) return -1;
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (!r0 && !r1) return -1;
    if (k == 0) return (m_last[k] == 0) ? 1 : 0;
    return (m_starve[k] == 3) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_last[k] = 1; m_starve[k] = 0; pv[k] = 0; po[k] = 0; pr[k] = 0; pe[k] = 0; pd[k] = 0;
    end
  endtask

  // One clock cycle: drive, check mid-cycle, advance, update model
  task automatic cycle(input logic i_rst, input logic i_r0, input logic i_w0,
                       input logic [31:0] i_a0, input logic [31:0] i_d0, input logic [3:0] i_s0,
                       input logic i_r1, input logic i_w1,
                       input logic [31:0] i_a1, input logic [31:0] i_d1, input logic [3:0] i_s1);
    int          g[2];
    logic [31:0] ea;
    logic [31:0] ed;
    logic [3:0]  es;
    logic        ew, inr;
    rst = i_rst; r0 = i_r0; w0 = i_w0; a0 = i_a0; d0 = i_d0; s0 = i_s0;
    r1 = i_r1; w1 = i_w1; a1 = i_a1; d1 = i_d1; s1 = i_s1;
    #4;
    for (int k = 0; k < 2; k++) begin
      g[k] = exp_grant(k);
      obs_g[k] = (gnt0_o[k] && gnt1_o[k]) ? -2 : gnt0_o[k] ? 0 : gnt1_o[k] ? 1 : -1;
      obs_rd0[k] = rd0_o[k]; obs_rv1[k] = rv1_o[k]; obs_err1[k] = err1_o[k];
      chk("gnt0", 32'(gnt0_o[k]), 32'(g[k] == 0));
      chk("gnt1", 32'(gnt1_o[k]), 32'(g[k] == 1));
      ea = (g[k] == 1) ? a1 : (g[k] == 0) ? a0 : 32'h0;
      ed = (g[k] == 1) ? d1 : d0;
      es = (g[k] == 1) ? s1 : (g[k] == 0) ? s0 : 4'h0;
      ew = (g[k] == 1) ? w1 : w0;
      inr = (ea < 32'd4096);
      chk("data_addr", daddr_o[k], ea);
      chk("data_size", 32'(dsize_o[k]), 32'(es));
      chk("data_write", 32'(dwr_o[k]), 32'(g[k] >= 0 && ew && inr));
      chk("data_read", 32'(drd_o[k]), 32'(g[k] >= 0 && !ew && inr));
      if (g[k] >= 0) chk("data_wr_data", dwdat_o[k], ed);
      if (!rst) begin
        chk("rvalid0", 32'(rv0_o[k]), 32'(pv[k] && po[k] == 0));
        chk("rvalid1", 32'(rv1_o[k]), 32'(pv[k] && po[k] == 1));
        chk("err0", 32'(err0_o[k]), 32'(pv[k] && po[k] == 0 && pe[k]));
        chk("err1", 32'(err1_o[k]), 32'(pv[k] && po[k] == 1 && pe[k]));
        chk("rd_data0", rd0_o[k], (pv[k] && po[k] == 0 && pr[k] && !pe[k]) ? pd[k] : 32'h0);
        chk("rd_data1", rd1_o[k], (pv[k] && po[k] == 1 && pr[k] && !pe[k]) ? pd[k] : 32'h0);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (i_rst) begin
        m_last[k] = 1; m_starve[k] = 0; pv[k] = 0;
      end else begin
        ea = (g[k] == 1) ? i_a1 : i_a0;
        ed = (g[k] == 1) ? i_d1 : i_d0;
        es = (g[k] == 1) ? i_s1 : i_s0;
        ew = (g[k] == 1) ? i_w1 : i_w0;
        inr = (ea < 32'd4096);
        pv[k] = (g[k] >= 0);
        if (g[k] >= 0) begin
          po[k] = g[k]; pr[k] = !ew; pe[k] = !inr;
          pd[k] = rmem[k][ea[11:2]];
          if (ew && inr)
            for (int b = 0; b < 4; b++)
              if (es[b]) rmem[k][ea[11:2]][8*b +: 8] = ed[8*b +: 8];
          m_last[k] = g[k];
        end
        if (i_r1 && g[k] != 1) m_starve[k] = (m_starve[k] < 255) ? m_starve[k] + 1 : 255;
        else                   m_starve[k] = 0;
      end
    end
  endtask

  task automatic idle(input logic i_rst);
    cycle(i_rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int exp_rr[6] = '{0, 1, 0, 1, 0, 1};
  int exp_pr[6] = '{0, 0, 0, 1, 0, 0};

  initial begin
    logic        rr0, rr1, rw0, rw1;
    logic [31:0] ra0, ra1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 1024; i++) rmem[k][i] = init_word(i);
    model_reset();
    rst = 1; preload = 1;
    r0 = 0; w0 = 0; a0 = 0; d0 = 0; s0 = 0; r1 = 0; w1 = 0; a1 = 0; d1 = 0; s1 = 0;
    @(posedge clk);
    #1;
    preload = 0;
    idle(1);
    idle(0);

    // Port 0 read of 0x10 alone
    cycle(0, 1, 0, 32'h10, 0, 4'hF, 0, 0, 0, 0, 0);
    idle(0);
    for (int k = 0; k < 2; k++) chk("tp1 rd_data", obs_rd0[k], 32'hDEADBEEF);

    // Continuous contention right after reset
    idle(1);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 0, 32'(4 * i), 0, 4'hF, 1, 0, 32'(64 + 4 * i), 0, 4'hF);
      chk("rr seq", 32'(obs_g[0]), 32'(exp_rr[i]));
      chk("prio seq", 32'(obs_g[1]), 32'(exp_pr[i]));
    end

    // Out-of-range write from port 1, then in-range write from port 0
    cycle(0, 0, 0, 0, 0, 0, 1, 1, 32'h1000, 32'h12345678, 4'b0011);
    cycle(0, 1, 1, 32'h20, 32'hAABBCCDD, 4'b1111, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      chk("oor rvalid1", 32'(obs_rv1[k]), 32'h1);
      chk("oor err1", 32'(obs_err1[k]), 32'h1);
    end
    idle(0);
    for (int k = 0; k < 2; k++) chk("write rd_data0", obs_rd0[k], 32'h0);
    cycle(0, 1, 0, 32'h20, 0, 4'hF, 0, 0, 0, 0, 0);
    idle(0);
    for (int k = 0; k < 2; k++) chk("readback", obs_rd0[k], 32'hAABBCCDD);

    // Reset while a read is in flight
    cycle(0, 1, 0, 32'h10, 0, 4'hF, 0, 0, 0, 0, 0);
    idle(1);
    idle(0);
    cycle(0, 1, 0, 32'h8, 0, 4'hF, 1, 0, 32'hC, 0, 4'hF);
    for (int k = 0; k < 2; k++) chk("post-reset winner", 32'(obs_g[k]), 32'h0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rr0 = 1'($urandom_range(0, 3) != 0);
      rr1 = 1'($urandom_range(0, 3) != 0);
      rw0 = 1'($urandom_range(0, 1));
      rw1 = 1'($urandom_range(0, 1));
      ra0 = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 4095));
      ra1 = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 4095));
      cycle(1'($urandom_range(0, 63) == 0), rr0, rw0, ra0, 32'($urandom), 4'($urandom),
            rr1, rw1, ra1, 32'($urandom), 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
